// File: rtl/ddr_multi_channel_arb.sv
// ddr_multi_channel_arb: arbitrates NUM_CH requesters onto one DDR port, one operation outstanding at a time.
// Ports: clock/reset_n (async, active-low); req_* per-channel request bundle with one-hot req_ready;
// rsp_done per-channel completion pulse with registered rsp_read_data/rsp_burst_data;
// redirect_valid drops reads of FLUSH_MASK channels; ddr_* drive and observe the DDR port; arb_busy = not idle.
module ddr_multi_channel_arb #(
    parameter int NUM_CH = 3,
    parameter int IDX_W = 19,
    parameter int DATA_W = 64,
    parameter int BURST_W = 512,
    parameter int ARB_MODE = 0,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = 'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*IDX_W-1:0]  req_index,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH-1:0]        req_burst,
    input  logic [NUM_CH*DATA_W-1:0] req_write_mask,
    input  logic [NUM_CH*DATA_W-1:0] req_write_data,
    output logic [NUM_CH-1:0]        rsp_done,
    output logic [DATA_W-1:0]        rsp_read_data,
    output logic [BURST_W-1:0]       rsp_burst_data,
    input  logic                     redirect_valid,
    output logic                     ddr_chip_enable,
    output logic [IDX_W-1:0]         ddr_index,
    output logic                     ddr_write_enable,
    output logic                     ddr_burst_mode,
    output logic [DATA_W-1:0]        ddr_opstore_write_mask,
    output logic [DATA_W-1:0]        ddr_opstore_write_data,
    input  logic [DATA_W-1:0]        ddr_opload_read_data,
    input  logic [BURST_W-1:0]       ddr_pc_read_inst,
    input  logic                     ddr_operation_done,
    input  logic                     ddr_ready,
    output logic                     arb_busy
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       owner;
    logic [PW-1:0]       gnt;
    logic                found;
    logic                drop;
    logic                lat_write;
    logic                lat_burst;
    logic [IDX_W-1:0]    lat_index;
    logic [DATA_W-1:0]   lat_mask;
    logic [DATA_W-1:0]   lat_data;
    logic [NUM_CH-1:0]   elig;
    logic                flush;
    logic                active;
    int                  c;

    assign elig   = req_valid & ~(FLUSH_MASK & {NUM_CH{redirect_valid}});
    // the latched operation is a read on a flushable channel and a redirect is present
    assign flush  = redirect_valid & FLUSH_MASK[owner] & ~lat_write;
    assign active = state != IDLE;

    // round-robin scans upward from rr_ptr with wrap; fixed priority scans from channel 0
    always_comb begin
        found = 1'b0;
        gnt = '0;
        c = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (ARB_MODE != 0) ? k : (int'(rr_ptr) + k) % NUM_CH;
            if (!found && elig[PW'(c)]) begin
                found = 1'b1;
                gnt = PW'(c);
            end
        end
    end

    assign req_ready              = (reset_n && state == IDLE && found) ? NUM_CH'(1) << gnt : '0;
    assign ddr_chip_enable        = state == ISSUE && ddr_ready && !flush;
    assign ddr_index              = active ? lat_index : '0;
    assign ddr_write_enable       = active & lat_write;
    assign ddr_burst_mode         = active & lat_burst;
    assign ddr_opstore_write_mask = active ? lat_mask : '0;
    assign ddr_opstore_write_data = active ? lat_data : '0;
    assign arb_busy               = active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            drop <= 1'b0;
            lat_write <= 1'b0;
            lat_burst <= 1'b0;
            lat_index <= '0;
            lat_mask <= '0;
            lat_data <= '0;
            rsp_done <= '0;
            rsp_read_data <= '0;
            rsp_burst_data <= '0;
        end else begin
            rsp_done <= '0;
            case (state)
                IDLE: if (found) begin
                    lat_index <= req_index[gnt*IDX_W +: IDX_W];
                    lat_write <= req_write[gnt];
                    lat_burst <= req_burst[gnt];
                    lat_mask <= req_write_mask[gnt*DATA_W +: DATA_W];
                    lat_data <= req_write_data[gnt*DATA_W +: DATA_W];
                    owner <= gnt;
                    drop <= 1'b0;
                    state <= ISSUE;
                    if (ARB_MODE == 0) rr_ptr <= (gnt == PW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
                end
                ISSUE: state <= flush ? IDLE : ddr_ready ? WAIT : ISSUE;
                WAIT: if (ddr_operation_done) begin
                    rsp_read_data <= ddr_opload_read_data;
                    rsp_burst_data <= ddr_pc_read_inst;
                    rsp_done <= (drop || flush) ? '0 : NUM_CH'(1) << owner;
                    drop <= 1'b0;
                    state <= IDLE;
                end else if (flush) begin
                    drop <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_multi_channel_arb.sv
// tb_ddr_multi_channel_arb: directed and random checks of ddr_multi_channel_arb against a transaction model.
module tb_ddr_multi_channel_arb;
    localparam int N = 3;
    localparam int IW = 19;
    localparam int DW = 64;
    localparam int BW = 512;
    localparam logic [N-1:0] FM = 3'b011;
    localparam logic [BW-1:0] PAT = {8{64'hA5A5_A5A5_A5A5_A5A5}};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] req_valid, req_write, req_burst, fp_valid;
    logic [N*IW-1:0] req_index;
    logic [N*DW-1:0] req_write_mask, req_write_data;
    logic redirect_valid, ddr_operation_done, ddr_ready;
    logic [DW-1:0] ddr_opload_read_data;
    logic [BW-1:0] ddr_pc_read_inst;
    logic [N-1:0] req_ready, rsp_done, fp_ready, fp_done;
    logic [DW-1:0] rsp_read_data, fp_rd;
    logic [BW-1:0] rsp_burst_data, fp_bd;
    logic ddr_chip_enable, ddr_write_enable, ddr_burst_mode, arb_busy;
    logic [IW-1:0] ddr_index, fp_idx;
    logic [DW-1:0] ddr_opstore_write_mask, ddr_opstore_write_data, fp_mask, fp_data;
    logic fp_ce, fp_we, fp_bm, fp_busy;

    always #5 clock = ~clock;

    ddr_multi_channel_arb #(.NUM_CH(N), .IDX_W(IW), .DATA_W(DW), .BURST_W(BW), .ARB_MODE(0), .FLUSH_MASK(FM)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_write(req_write), .req_burst(req_burst),
        .req_write_mask(req_write_mask), .req_write_data(req_write_data),
        .rsp_done(rsp_done), .rsp_read_data(rsp_read_data), .rsp_burst_data(rsp_burst_data),
        .redirect_valid(redirect_valid), .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_opstore_write_mask(ddr_opstore_write_mask), .ddr_opstore_write_data(ddr_opstore_write_data),
        .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
        .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready), .arb_busy(arb_busy));

    ddr_multi_channel_arb #(.NUM_CH(N), .IDX_W(IW), .DATA_W(DW), .BURST_W(BW), .ARB_MODE(1), .FLUSH_MASK(3'b001)) dut_fp (
        .clock(clock), .reset_n(reset_n), .req_valid(fp_valid), .req_ready(fp_ready),
        .req_index(req_index), .req_write(req_write), .req_burst(req_burst),
        .req_write_mask(req_write_mask), .req_write_data(req_write_data),
        .rsp_done(fp_done), .rsp_read_data(fp_rd), .rsp_burst_data(fp_bd),
        .redirect_valid(1'b0), .ddr_chip_enable(fp_ce), .ddr_index(fp_idx),
        .ddr_write_enable(fp_we), .ddr_burst_mode(fp_bm),
        .ddr_opstore_write_mask(fp_mask), .ddr_opstore_write_data(fp_data),
        .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
        .ddr_operation_done(1'b1), .ddr_ready(1'b1), .arb_busy(fp_busy));

    int total = 0;
    int bad = 0;

    // transaction model: one pending op, whether it has been strobed, and whether it is to be dropped
    bit m_busy = 0, m_strobed = 0, m_drop = 0, m_wr = 0, m_bu = 0;
    int m_owner = 0, m_ptr = 0;
    logic [IW-1:0] m_idx = '0;
    logic [DW-1:0] m_mask = '0, m_data = '0, m_rd = '0;
    logic [BW-1:0] m_bd = '0;
    logic [N-1:0] m_done = '0;
    int dcnt = 0, lat = 2, strobes = 0;
    int done_cnt[N];
    int grants[$];
    bit last_ce_burst = 0;
    logic [IW-1:0] last_ce_index = '0;
    bit pulsed;
    int wins, d0, fp_seen;
    logic [N-1:0] got;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] e);
        for (int k = 0; k < N; k++) if (e[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic quiet();
        req_valid = '0; req_write = '0; req_burst = '0; req_index = '0;
        req_write_mask = '0; req_write_data = '0; redirect_valid = 1'b0;
        ddr_ready = 1'b1; ddr_operation_done = 1'b0; lat = 2;
        ddr_opload_read_data = 64'h0123_4567_89AB_CDEF;
        ddr_pc_read_inst = {16{32'h1357_9BDF}};
    endtask

    task automatic ddr_drive(input bit spur);
        ddr_operation_done = (dcnt == 1) || (spur && dcnt == 0 && $urandom_range(5) == 0);
    endtask

    task automatic drive_rand();
        req_valid = N'($urandom);
        req_write = N'($urandom);
        req_burst = N'($urandom);
        req_index = (N*IW)'({$urandom, $urandom});
        req_write_mask = (N*DW)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        req_write_data = (N*DW)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        redirect_valid = $urandom_range(7) == 0;
        ddr_ready = $urandom_range(3) != 0;
        lat = $urandom_range(1, 3);
        ddr_opload_read_data = {$urandom, $urandom};
        for (int w = 0; w < 16; w++) ddr_pc_read_inst[w*32 +: 32] = $urandom;
        ddr_drive(1);
    endtask

    task automatic model_reset();
        m_busy = 0; m_strobed = 0; m_drop = 0; m_ptr = 0; m_rd = '0; m_bd = '0; m_done = '0; dcnt = 0;
    endtask

    // called just after a falling edge with inputs set; checks outputs then advances the model
    task automatic cycle();
        logic [N-1:0] elig, er;
        int g;
        bit fl, ce;
        #1;
        elig = req_valid & ~(FM & {N{redirect_valid}});
        g = m_busy ? -1 : pick(elig);
        er = (g < 0) ? '0 : N'(1) << g;
        fl = m_busy && redirect_valid && FM[m_owner] && !m_wr;
        ce = m_busy && !m_strobed && ddr_ready && !fl;
        check("req_ready", BW'(req_ready), BW'(er));
        check("chip_enable", BW'(ddr_chip_enable), BW'(ce));
        check("ddr_index", BW'(ddr_index), BW'(m_busy ? m_idx : '0));
        check("write_enable", BW'(ddr_write_enable), BW'(m_busy & m_wr));
        check("burst_mode", BW'(ddr_burst_mode), BW'(m_busy & m_bu));
        check("write_mask", BW'(ddr_opstore_write_mask), BW'(m_busy ? m_mask : '0));
        check("write_data", BW'(ddr_opstore_write_data), BW'(m_busy ? m_data : '0));
        check("rsp_done", BW'(rsp_done), BW'(m_done));
        check("read_data", BW'(rsp_read_data), BW'(m_rd));
        check("burst_data", rsp_burst_data, m_bd);
        check("arb_busy", BW'(arb_busy), BW'(m_busy));
        if (ddr_chip_enable) begin
            strobes++;
            last_ce_burst = ddr_burst_mode;
            last_ce_index = ddr_index;
        end
        for (int i = 0; i < N; i++) done_cnt[i] += int'(rsp_done[i]);
        if (g >= 0) grants.push_back(g);
        m_done = '0;
        if (!m_busy) begin
            if (g >= 0) begin
                m_idx = req_index[g*IW +: IW];
                m_wr = req_write[g];
                m_bu = req_burst[g];
                m_mask = req_write_mask[g*DW +: DW];
                m_data = req_write_data[g*DW +: DW];
                m_owner = g;
                m_busy = 1; m_strobed = 0; m_drop = 0;
                m_ptr = (g + 1) % N;
            end
        end else if (!m_strobed) begin
            if (fl) m_busy = 0;
            else if (ddr_ready) m_strobed = 1;
        end else if (ddr_operation_done) begin
            m_rd = ddr_opload_read_data;
            m_bd = ddr_pc_read_inst;
            if (!(m_drop || fl)) m_done = N'(1) << m_owner;
            m_busy = 0;
        end else if (fl) begin
            m_drop = 1;
        end
        if (ce) dcnt = lat;
        else if (dcnt > 0) dcnt--;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        quiet();
        fp_valid = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // all channels requesting continuously under round-robin
        req_valid = '1;
        for (int k = 0; k < 100 && grants.size() < 6; k++) begin ddr_drive(0); cycle(); end
        req_valid = '0;
        check("rr_count", BW'(grants.size()), BW'(6));
        for (int k = 0; k < 6 && k < grants.size(); k++) check("rr_grant", BW'(grants[k]), BW'(k % 3));
        repeat (20) begin ddr_drive(0); cycle(); end
        for (int i = 0; i < N; i++) check("rr_dones", BW'(done_cnt[i]), BW'(2));

        // channel 0 burst read
        quiet();
        d0 = done_cnt[0]; strobes = 0;
        req_valid = 3'b001; req_burst = 3'b001; req_index = (N*IW)'(19'h1234); ddr_pc_read_inst = PAT;
        ddr_drive(0); cycle();
        req_valid = '0;
        repeat (10) begin ddr_drive(0); cycle(); end
        check("burst_strobes", BW'(strobes), BW'(1));
        check("burst_mode_at_strobe", BW'(last_ce_burst), BW'(1));
        check("burst_index", BW'(last_ce_index), BW'(19'h1234));
        check("burst_rsp", rsp_burst_data, PAT);
        check("burst_done", BW'(done_cnt[0] - d0), BW'(1));

        // channel 0 read dropped by redirect in WAIT, then a normal read
        quiet();
        lat = 3; d0 = done_cnt[0]; pulsed = 0;
        req_valid = 3'b001;
        ddr_drive(0); cycle();
        req_valid = '0;
        repeat (12) begin
            redirect_valid = !pulsed && m_busy && m_strobed;
            if (redirect_valid) pulsed = 1;
            ddr_drive(0); cycle();
        end
        redirect_valid = 1'b0;
        check("drop_done", BW'(done_cnt[0] - d0), BW'(0));
        req_valid = 3'b001;
        ddr_drive(0); cycle();
        req_valid = '0;
        repeat (12) begin ddr_drive(0); cycle(); end
        check("after_drop_done", BW'(done_cnt[0] - d0), BW'(1));

        // channel 1 write under redirect in ISSUE and WAIT
        d0 = done_cnt[1];
        req_valid = 3'b010; req_write = 3'b010;
        ddr_drive(0); cycle();
        req_valid = '0; ddr_ready = 1'b0; redirect_valid = 1'b1;
        ddr_drive(0); cycle();
        ddr_ready = 1'b1; redirect_valid = 1'b0;
        ddr_drive(0); cycle();
        redirect_valid = 1'b1;
        ddr_drive(0); cycle();
        redirect_valid = 1'b0;
        repeat (10) begin ddr_drive(0); cycle(); end
        check("write_redirect_done", BW'(done_cnt[1] - d0), BW'(1));

        // DDR not ready for 5 cycles while in ISSUE
        quiet();
        strobes = 0;
        req_valid = 3'b100; req_index[2*IW +: IW] = 19'h5A5A;
        ddr_drive(0); cycle();
        req_valid = '0; ddr_ready = 1'b0;
        repeat (5) begin
            ddr_drive(0); cycle();
            check("stall_index", BW'(ddr_index), BW'(19'h5A5A));
        end
        check("stall_no_strobe", BW'(strobes), BW'(0));
        ddr_ready = 1'b1;
        repeat (10) begin ddr_drive(0); cycle(); end
        check("stall_one_strobe", BW'(strobes), BW'(1));

        // asynchronous reset while waiting on DDR
        quiet();
        lat = 3;
        req_valid = 3'b001;
        ddr_drive(0); cycle();
        req_valid = '0;
        for (int k = 0; k < 10 && !(m_busy && m_strobed); k++) begin ddr_drive(0); cycle(); end
        check("pre_reset_busy", BW'(arb_busy), BW'(1));
        req_valid = '1;
        reset_n = 1'b0;
        #1;
        check("rst_busy", BW'(arb_busy), BW'(0));
        check("rst_ready", BW'(req_ready), BW'(0));
        check("rst_ce", BW'(ddr_chip_enable), BW'(0));
        check("rst_index", BW'(ddr_index), BW'(0));
        check("rst_we", BW'(ddr_write_enable), BW'(0));
        check("rst_done", BW'(rsp_done), BW'(0));
        check("rst_rd", BW'(rsp_read_data), BW'(0));
        check("rst_bd", rsp_burst_data, BW'(0));
        model_reset();
        repeat (2) @(negedge clock);
        req_valid = '0;
        reset_n = 1'b1;
        repeat (6) begin ddr_drive(0); cycle(); end

        // random traffic
        repeat (3000) begin drive_rand(); cycle(); end

        // fixed priority instance: channel 1 beats channel 2 until it drops valid
        quiet();
        repeat (8) begin ddr_drive(0); cycle(); end
        fp_valid = 3'b110; wins = 0;
        repeat (30) begin
            #1;
            if (fp_ready != '0) begin
                check("fp_grant", BW'(fp_ready), BW'(3'b010));
                wins++;
            end
            if (fp_done != '0) check("fp_done", BW'(fp_done), BW'(3'b010));
            @(negedge clock);
        end
        check("fp_wins", BW'(wins), BW'(10));
        fp_valid = 3'b100; got = '0; fp_seen = 0;
        for (int k = 0; k < 10 && fp_seen == 0; k++) begin
            #1;
            if (fp_ready != '0) begin got = fp_ready; fp_seen = 1; end
            @(negedge clock);
        end
        check("fp_low_grant", BW'(got), BW'(3'b100));
        fp_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
